sap_ram16x8: RTL and testbench



---
 rtl/sap_pkg.sv | 10 +
 rtl/sap_bus_drv.sv | 19 +
 rtl/sap_ram16x8.sv | 43 ++++
 tb/tb_sap_ram16x8.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants and word/address types for the SAP datapath.
package sap_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/sap_bus_drv.sv
// Enable-gated bus driver: outputs zero when disabled so drivers can be OR-combined.
module sap_bus_drv
    import sap_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out = d;
        end
    end

endmodule

// File: rtl/sap_ram16x8.sv
// 16x8 SAP program/data RAM: synchronous write with synchronous clear, combinational read.
module sap_ram16x8
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W = sap_pkg::DATA_W,
    parameter int unsigned ADDR_W = sap_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] BusIn,
    input  logic [ADDR_W-1:0] Addrs,
    input  logic              RAMOut,
    input  logic              RAMIn,
    output logic [DATA_W-1:0] BusOut
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_word;

    // Reset clears every word and takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (RAMIn) begin
            mem[Addrs] <= BusIn;
        end
    end

    assign rd_word = mem[Addrs];

    sap_bus_drv #(
        .W (DATA_W)
    ) u_bus_drv (
        .en  (RAMOut),
        .d   (rd_word),
        .out (BusOut)
    );

endmodule

// File: tb/tb_sap_ram16x8.sv
// Directed self-checking bench for sap_ram16x8.
module tb_sap_ram16x8;

    logic       clk;
    logic       rst;
    logic [7:0] BusIn;
    logic [3:0] Addrs;
    logic       RAMOut;
    logic       RAMIn;
    logic [7:0] BusOut;

    int unsigned vectors;
    int unsigned miscompares;

    sap_ram16x8 dut (
        .clk    (clk),
        .rst    (rst),
        .BusIn  (BusIn),
        .Addrs  (Addrs),
        .RAMOut (RAMOut),
        .RAMIn  (RAMIn),
        .BusOut (BusOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        RAMIn = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        Addrs = a;
        BusIn = d;
        RAMIn = 1'b1;
        @(negedge clk);
        RAMIn = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        RAMOut = 1'b1;
        for (int a = 0; a < 16; a++) begin
            Addrs = 4'(a);
            #1;
            vectors++;
            if (BusOut !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_clear addr=%0d got=%h exp=00", a, BusOut);
            end
        end
    endtask

    task automatic test_disabled_read();
        write_word(4'd9, 8'hC3);
        RAMOut = 1'b0;
        for (int a = 0; a < 16; a += 3) begin
            Addrs = 4'(a);
            #1;
            vectors++;
            if (BusOut !== 8'h00) begin
                miscompares++;
                $display("FAIL disabled_read addr=%0d got=%h exp=00", a, BusOut);
            end
        end
        Addrs = 4'd9;
        #1;
        vectors++;
        if (BusOut !== 8'h00) begin
            miscompares++;
            $display("FAIL disabled_read_written got=%h exp=00", BusOut);
        end
        RAMOut = 1'b1;
        #1;
        vectors++;
        if (BusOut !== 8'hC3) begin
            miscompares++;
            $display("FAIL enabled_read_written got=%h exp=c3", BusOut);
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        RAMOut = 1'b0;
        write_word(4'd2, 8'h09);
        RAMOut = 1'b1;
        Addrs  = 4'd2;
        #1;
        vectors++;
        if (BusOut !== 8'h09) begin
            miscompares++;
            $display("FAIL write_read addr2 got=%h exp=09", BusOut);
        end
        Addrs = 4'd3;
        #1;
        vectors++;
        if (BusOut !== 8'h00) begin
            miscompares++;
            $display("FAIL write_read addr3 got=%h exp=00", BusOut);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] exp;
        apply_reset();
        write_word(4'd0,  8'hA5);
        write_word(4'd15, 8'h5A);
        write_word(4'd7,  8'hFF);
        RAMOut = 1'b1;
        for (int a = 0; a < 16; a++) begin
            case (a)
                0:       exp = 8'hA5;
                15:      exp = 8'h5A;
                7:       exp = 8'hFF;
                default: exp = 8'h00;
            endcase
            Addrs = 4'(a);
            #1;
            vectors++;
            if (BusOut !== exp) begin
                miscompares++;
                $display("FAIL boundary addr=%0d got=%h exp=%h", a, BusOut, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        write_word(4'd4, 8'h11);
        @(negedge clk);
        rst   = 1'b1;
        RAMIn = 1'b1;
        Addrs = 4'd4;
        BusIn = 8'h33;
        @(negedge clk);
        rst   = 1'b0;
        RAMIn = 1'b0;
        RAMOut = 1'b1;
        for (int a = 0; a < 16; a++) begin
            Addrs = 4'(a);
            #1;
            vectors++;
            if (BusOut !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_priority addr=%0d got=%h exp=00", a, BusOut);
            end
        end
    endtask

    task automatic test_write_through();
        @(negedge clk);
        RAMOut = 1'b1;
        RAMIn  = 1'b1;
        Addrs  = 4'd5;
        BusIn  = 8'h6C;
        #1;
        vectors++;
        if (BusOut !== 8'h00) begin
            miscompares++;
            $display("FAIL write_through_before got=%h exp=00", BusOut);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (BusOut !== 8'h6C) begin
            miscompares++;
            $display("FAIL write_through_after got=%h exp=6c", BusOut);
        end
        @(negedge clk);
        RAMIn = 1'b0;
        Addrs = 4'd6;
        #1;
        vectors++;
        if (BusOut !== 8'h00) begin
            miscompares++;
            $display("FAIL write_through_neighbour got=%h exp=00", BusOut);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b0;
        BusIn  = '0;
        Addrs  = '0;
        RAMOut = 1'b0;
        RAMIn  = 1'b0;

        test_reset();
        test_disabled_read();
        test_write_read();
        test_boundaries();
        test_reset_priority();
        test_write_through();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
